// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding and
// default sizing of the requester vector and hold limit.
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int N_DEF        = 8;
  localparam int W_DEF        = 3;
  localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotated priority encoder: the first set bit of (req & ~mask) when the
// search starts at ptr and wraps modulo N. Purely combinational.
module rr_pick
  import rr_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic [N-1:0] mask,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [N-1:0] cand;
  logic [W-1:0] pos;

  assign cand = req & ~mask;

  // Walk ptr, ptr+1, ... with natural W-bit wrap (N is a power of two);
  // the first candidate hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = ptr + W'(i);
      if (!found && cand[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for eight requesters with grant hold and optional
// preemption after MAX_HOLD cycles of ownership while others wait.
//
// state | meaning
// ------+------------------------------------------
// IDLE  | no owner, all outputs zero
// BUSY  | resource owned by requester grant_code
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int W        = W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_code,
  output logic         grant_valid
);

  // hold_cnt only needs to reach MAX_HOLD-1; keep at least one bit so a
  // disabled limit still elaborates cleanly.
  localparam int HCW       = (MAX_HOLD <= 2) ? 1 : $clog2(MAX_HOLD);
  localparam int HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HCW-1:0] HOLD_LAST_C = HCW'(HOLD_LAST);

  state_t         state, state_nxt;
  logic [W-1:0]   ptr, ptr_nxt;
  logic [HCW-1:0] hold_cnt, hold_nxt;

  logic [N-1:0]   grant_nxt;
  logic [W-1:0]   code_nxt;
  logic           valid_nxt;

  logic [N-1:0]   owner_oh;
  logic           owner_req;
  logic           others;
  logic           preempt;
  logic           rearb;

  logic [N-1:0]   pick_mask;
  logic [W-1:0]   pick_idx;
  logic           pick_found;

  assign owner_oh  = N'(1) << grant_code;
  assign owner_req = |(req & owner_oh);
  assign others    = |(req & ~owner_oh);

  // The owner is masked only when it is being preempted; on release its
  // bit is already low, so the plain search does the right thing.
  assign preempt   = (state == BUSY) && owner_req && (MAX_HOLD != 0) &&
                     (hold_cnt == HOLD_LAST_C) && others;
  assign rearb     = (state == IDLE) || !owner_req || preempt;
  assign pick_mask = preempt ? owner_oh : '0;

  rr_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .mask  (pick_mask),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // State, rotation pointer and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next state: re-arbitrate on idle, release or preemption, else hold.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    if (rearb) begin
      state_nxt = pick_found ? BUSY : IDLE;
      hold_nxt  = '0;
      if (pick_found) begin
        ptr_nxt = pick_idx + W'(1);
      end
    end else if (hold_cnt != HOLD_LAST_C) begin
      hold_nxt = hold_cnt + HCW'(1);
    end
  end

  // Next outputs derived from the same decision so the three always agree.
  always_comb begin
    valid_nxt = (state_nxt == BUSY);
    code_nxt  = grant_code;
    if (rearb) begin
      code_nxt = pick_found ? pick_idx : '0;
    end
    grant_nxt = valid_nxt ? (N'(1) << code_nxt) : '0;
  end

  // Registered grant outputs; reset drops the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      grant_code  <= '0;
      grant_valid <= 1'b0;
    end else begin
      grant       <= grant_nxt;
      grant_code  <= code_nxt;
      grant_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: one instance with a hold limit of 4 and
// one with preemption disabled, both driven by the same request vector.
module tb_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;

  logic [7:0] grant;
  logic [2:0] grant_code;
  logic       grant_valid;

  logic [7:0] grant0;
  logic [2:0] grant_code0;
  logic       grant_valid0;

  int n_chk;
  int n_err;

  logic [7:0] req_prev;
  logic [7:0] exp_oh;

  rr_arbiter #(.N(8), .W(3), .MAX_HOLD(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_code  (grant_code),
    .grant_valid (grant_valid)
  );

  rr_arbiter #(.N(8), .W(3), .MAX_HOLD(0)) u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant0),
    .grant_code  (grant_code0),
    .grant_valid (grant_valid0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] c, input logic v);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_code"}, 32'(grant_code), 32'(c));
    chk({tag, "_valid"}, 32'(grant_valid), 32'(v));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 8'h00;

    // Reset state
    repeat (2) tick();
    chk_out("rst", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("idle0", 8'h00, 3'd0, 1'b0);

    // First grant, then asynchronous reset mid-grant
    req = 8'hFF;
    tick();
    chk_out("first", 8'h01, 3'd0, 1'b1);
    tick();
    chk_out("first_hold", 8'h01, 3'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 3'd0, 1'b0);
    chk("async_rst_u0", 32'(grant0), 32'h0);
    rst_n = 1'b1;
    tick();
    chk_out("post_rst", 8'h01, 3'd0, 1'b1);

    // Rotation: each owner holds two cycles then drops for one
    for (int o = 0; o < 8; o++) begin
      exp_oh = 8'h01 << o;
      tick();
      chk("rot_hold", 32'(grant), 32'(exp_oh));
      req = ~exp_oh;
      tick();
      req = 8'hFF;
      exp_oh = 8'h01 << ((o + 1) % 8);
      chk("rot_next", 32'(grant), 32'(exp_oh));
      chk("rot_code", 32'(grant_code), 32'((o + 1) % 8));
      chk("rot_valid", 32'(grant_valid), 32'h1);
    end

    // Wrap and pointer
    req = 8'h00;
    tick();
    chk_out("to_idle", 8'h00, 3'd0, 1'b0);
    req = 8'h80;
    tick();
    chk_out("g7", 8'h80, 3'd7, 1'b1);
    req = 8'h00;
    tick();
    chk_out("g7_rel", 8'h00, 3'd0, 1'b0);
    req = 8'h81;
    tick();
    chk_out("wrap0", 8'h01, 3'd0, 1'b1);
    req = 8'h80;
    tick();
    req = 8'h81;
    chk_out("wrap7", 8'h80, 3'd7, 1'b1);
    req = 8'h01;
    tick();
    chk_out("back0", 8'h01, 3'd0, 1'b1);
    req = 8'h00;
    tick();
    chk_out("idle1", 8'h00, 3'd0, 1'b0);

    // Preemption after four cycles of ownership (limit 4 only)
    req = 8'h04;
    tick();
    chk_out("pre_g2", 8'h04, 3'd2, 1'b1);
    req = 8'h24;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pre_keep", 32'(grant), 32'h04);
      chk("pre_keep_u0", 32'(grant0), 32'h04);
    end
    tick();
    chk_out("pre_move", 8'h20, 3'd5, 1'b1);
    chk("nopre_u0", 32'(grant0), 32'h04);
    tick();
    chk("pre5_hold", 32'(grant), 32'h20);
    req = 8'h04;
    tick();
    chk_out("pre_back2", 8'h04, 3'd2, 1'b1);
    chk("nopre_u0_b", 32'(grant0), 32'h04);

    // Lone owner keeps the grant without glitches
    req = 8'h08;
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("lone", 32'(grant), 32'h08);
      chk("lone_u0", 32'(grant0), 32'h08);
    end
    chk_out("lone_end", 8'h08, 3'd3, 1'b1);

    // Idle
    req = 8'h00;
    repeat (2) begin
      tick();
      chk_out("idle2", 8'h00, 3'd0, 1'b0);
    end

    // Random requests: invariants against the request seen at each edge
    for (int k = 0; k < 200; k++) begin
      req_prev = req;
      tick();
      chk("rnd_valid", 32'(grant_valid), 32'(|req_prev));
      chk("rnd_onehot", 32'(grant), grant_valid ? 32'(8'h01 << grant_code) : 32'h0);
      chk("rnd_code0", 32'(grant_valid ? 3'd0 : grant_code), 32'h0);
      chk("rnd_subset", 32'(grant & ~req_prev), 32'h0);
      chk("rnd_subset_u0", 32'(grant0 & ~req_prev), 32'h0);
      req = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) req = req & 8'h0F;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
